jpeg_bitstream_packer: RTL and testbench
========================================

Name: jpeg_bitstream_packer

Overview:
Sits directly downstream of the Huffman encode controller. It takes variable-length code words: DC code plus amplitude, AC code plus amplitude, and EOB/ZRL. It packs them MSB-first into a contiguous bitstream and emits bytes. After every 0xFF data byte it inserts a 0x00 stuff byte. On flush it pads the final partial byte with 1s. Output is a byte stream with valid/ready, ready for the file/marker writer.

Parameters:
MAX_LEN, 32, maximum code-word length in bits accepted per transfer.
ACC_W, 64, bit-accumulator width; must be >= MAX_LEN + 8.
PAD_BIT, 1'b1, value of the fill bits used to complete the last byte on flush.

Ports:
clock  in  1  single clock, all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  code word present.
in_ready  out  1  packer can accept the word this cycle.
in_bits  in  MAX_LEN  code word, right-aligned; bits above in_len are ignored (masked).
in_len  in  6  number of valid bits, 0..MAX_LEN; 0 is a legal no-op.
in_flush  in  1  with the accepted word: append in_bits, then pad and drain all bits.
out_valid  out  1  out_byte valid.
out_ready  in  1  downstream accepts the byte.
out_byte  out  8  packed/stuffed byte.
flush_done  out  1  one-cycle pulse when the flush has completed.
busy  out  1  accumulator non-empty, or output register full, or not in RUN state.

Behaviour:
- Reset (sync, active-high): acc=0, cnt=0, state=RUN, out_valid=0, out_byte=0, flush_done=0, in_ready=0 in the reset cycle; in_ready=1 from the first cycle after.
- Accept condition: in_valid && in_ready.
- in_ready = (state==RUN) && (cnt <= ACC_W-MAX_LEN).
- Append: masked in_bits is placed at acc[ACC_W-1-cnt -: in_len]; cnt += in_len.
- in_len > MAX_LEN is illegal: simulation assertion; RTL clamps the length to MAX_LEN.
- Output register is free when !out_valid || out_ready. A byte loads into it only when it is free.
- Extraction in RUN: if cnt >= 8 and the output register is free, load acc[ACC_W-1:ACC_W-8], shift acc left by 8, cnt -= 8.
  - Append and extract in the same cycle are allowed: cnt_next = cnt + in_len - 8.
- Latency: a word accepted at edge k that leaves cnt >= 8 with the output register free gives out_valid=1 after edge k+1.
- States:
  - RUN: normal operation.
    - Loading 0xFF -> STUFF.
    - Accepting a word with in_flush -> FLUSH; the word itself is appended in that cycle.
  - STUFF: the next free slot loads 0x00, with no acc consumption and in_ready=0. Then return to the saved state (RUN or FLUSH).
  - FLUSH: in_ready=0.
    - Drain full bytes as in RUN.
    - When 0 < cnt < 8: load {acc top cnt bits, (8-cnt) x PAD_BIT}, set cnt=0. A padded 0xFF also goes through STUFF.
    - When cnt==0, no stuff pending, and the output register is free or being consumed -> DONE.
  - DONE: flush_done=1 for exactly one cycle, then RUN. acc is guaranteed 0.
- Flush with cnt==0 and no pending bits: no byte is emitted; flush_done is asserted.
- out_byte and out_valid are stable while out_valid && !out_ready. Bytes are never dropped or duplicated.
- Reset asserted mid-operation discards all buffered bits, any pending stuff, and the output byte. out_valid=0 after the edge.

Decomposition:
- Package jpeg_enc_pkg:
  - constants JPEG_STUFF_TRIGGER=8'hFF and JPEG_STUFF_BYTE=8'h00;
  - state enum {RUN, STUFF, FLUSH, DONE};
  - localparam width for the cnt field, $clog2(ACC_W+1).
- One natural sub-module: jpeg_byte_stuffer. It is a one-entry byte output register with the 0xFF->0x00 insertion and the valid/ready hold.
- Top keeps the accumulator, the length masking, the padding, and the flush FSM.

Test Plan:
1. (0xA,len4) then (0x5,len4), out_ready=1 -> single byte 0xA5. out_valid rises 1 edge after the second accept; busy=0 afterwards.
2. (0xFF,len8) then (0x12,len8) -> bytes 0xFF, 0x00, 0x12 in order. in_ready=0 during the STUFF cycle.
3. (0b101,len3,in_flush=1) -> byte 0xBF, then flush_done pulse for 1 cycle. Separately, (0xF,len4,flush) -> 0xFF, 0x00, then flush_done.
4. out_ready=0 for 20 cycles while pushing five (0xDEADBEEF,len32) words:
   - in_ready drops once cnt > 32;
   - after release, the 20 bytes DE AD BE EF repeat in exact order;
   - out_byte stays stable while stalled.
5. Flush with an empty accumulator (in_len=0,in_flush=1) -> no out_valid; flush_done 1 cycle later. Also a 13-bit word followed by a 3-bit word -> exactly 2 bytes, no padding.
6. Push (0x3FF,len10) with out_ready=0, then assert reset 1 cycle:
   - out_valid=0 and flush_done=0 after the edge; busy=0;
   - a following (0x81,len8) yields exactly one byte 0x81.

Source files
------------

// File: rtl/jpeg_enc_pkg.sv
// rtl/jpeg_enc_pkg.sv - shared constants, FSM state type and width helper for the JPEG entropy packer
package jpeg_enc_pkg;

    localparam logic [7:0] JPEG_STUFF_TRIGGER = 8'hFF;
    localparam logic [7:0] JPEG_STUFF_BYTE    = 8'h00;

    localparam int JPEG_MAX_LEN = 32;
    localparam int JPEG_ACC_W   = 64;
    localparam int JPEG_CNT_W   = $clog2(JPEG_ACC_W + 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STUFF = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } jpeg_state_e;

    // Bit-count field must represent the full accumulator occupancy, ACC_W inclusive.
    function automatic int jpeg_cnt_width(input int acc_w);
        return $clog2(acc_w + 1);
    endfunction

endpackage

// File: rtl/jpeg_byte_stuffer.sv
// rtl/jpeg_byte_stuffer.sv - one-entry output byte register that follows every 0xFF with a 0x00
module jpeg_byte_stuffer
    import jpeg_enc_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    output logic [7:0] out_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       slot_free,
    output logic       stuff_pending
);

    assign slot_free = !out_valid || out_ready;
    assign s_tready  = slot_free && !stuff_pending;

    // A pending stuff byte owns the next free slot ahead of any new data byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_byte      <= 8'h00;
            stuff_pending <= 1'b0;
        end else if (slot_free) begin
            if (stuff_pending) begin
                out_valid     <= 1'b1;
                out_byte      <= JPEG_STUFF_BYTE;
                stuff_pending <= 1'b0;
            end else if (s_tvalid) begin
                out_valid     <= 1'b1;
                out_byte      <= s_tdata;
                stuff_pending <= (s_tdata == JPEG_STUFF_TRIGGER);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/jpeg_bitstream_packer.sv
// rtl/jpeg_bitstream_packer.sv - packs variable-length code words MSB-first into a stuffed byte stream
module jpeg_bitstream_packer
    import jpeg_enc_pkg::*;
#(
    parameter int   MAX_LEN = JPEG_MAX_LEN,
    parameter int   ACC_W   = JPEG_ACC_W,
    parameter logic PAD_BIT = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAX_LEN-1:0] in_bits,
    input  logic [5:0]         in_len,
    input  logic               in_flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_byte,
    output logic               flush_done,
    output logic               busy
);

    localparam int               CNT_W     = jpeg_cnt_width(ACC_W);
    localparam logic [5:0]       MAX_LEN_L = 6'(MAX_LEN);
    localparam logic [CNT_W-1:0] ACC_W_C   = CNT_W'(ACC_W);
    localparam logic [CNT_W-1:0] IN_LIMIT  = CNT_W'(ACC_W - MAX_LEN);
    localparam logic [CNT_W-1:0] EIGHT     = CNT_W'(8);

    jpeg_state_e        state, state_next, saved_state, saved_next;
    logic [ACC_W-1:0]   acc, acc_sum, acc_next;
    logic [CNT_W-1:0]   cnt, cnt_sum, cnt_next, shamt;
    logic [5:0]         len_c;
    logic [MAX_LEN-1:0] bits_m;
    logic [7:0]         s_tdata, pad_byte;
    logic               accept, byte_avail, pad_avail;
    logic               s_tvalid, s_tready, fire, slot_free, stuff_pending;

    assign len_c  = (in_len > MAX_LEN_L) ? MAX_LEN_L : in_len;
    assign bits_m = in_bits & ~({MAX_LEN{1'b1}} << len_c);
    assign accept = in_valid && in_ready;
    assign shamt  = ACC_W_C - cnt - CNT_W'(len_c);

    jpeg_byte_stuffer u_stuffer (
        .clock         (clock),
        .reset         (reset),
        .s_tdata       (s_tdata),
        .s_tvalid      (s_tvalid),
        .s_tready      (s_tready),
        .out_byte      (out_byte),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .slot_free     (slot_free),
        .stuff_pending (stuff_pending)
    );

    // Bits below cnt are always zero, so padding is a plain OR of the fill pattern.
    always_comb begin
        byte_avail = (state == RUN || state == FLUSH) && (cnt >= EIGHT);
        pad_avail  = (state == FLUSH) && (cnt != '0) && (cnt < EIGHT);
        pad_byte   = acc[ACC_W-1 -: 8] | ({8{PAD_BIT}} >> cnt);
        s_tvalid   = byte_avail || pad_avail;
        s_tdata    = byte_avail ? acc[ACC_W-1 -: 8] : pad_byte;
        fire       = s_tvalid && s_tready;
        acc_sum    = accept ? (acc | (ACC_W'(bits_m) << shamt)) : acc;
        cnt_sum    = accept ? (cnt + CNT_W'(len_c)) : cnt;
        acc_next   = acc_sum;
        cnt_next   = cnt_sum;
        if (fire && byte_avail) begin
            acc_next = acc_sum << 8;
            cnt_next = cnt_sum - EIGHT;
        end else if (fire) begin
            acc_next = '0;
            cnt_next = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RUN;
            saved_state <= RUN;
            acc         <= '0;
            cnt         <= '0;
        end else begin
            state       <= state_next;
            saved_state <= saved_next;
            acc         <= acc_next;
            cnt         <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        saved_next = saved_state;
        case (state)
            RUN: begin
                if (fire && s_tdata == JPEG_STUFF_TRIGGER) begin
                    state_next = STUFF;
                    saved_next = (accept && in_flush) ? FLUSH : RUN;
                end else if (accept && in_flush) begin
                    state_next = FLUSH;
                end
            end
            STUFF: begin
                if (slot_free) state_next = saved_state;
            end
            FLUSH: begin
                if (fire && s_tdata == JPEG_STUFF_TRIGGER) begin
                    state_next = STUFF;
                    saved_next = FLUSH;
                end else if (cnt == '0 && !stuff_pending && slot_free) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        in_ready   = !reset && (state == RUN) && (cnt <= IN_LIMIT);
        flush_done = !reset && (state == DONE);
        busy       = (cnt != '0) || out_valid || (state != RUN);
    end

    assert property (@(posedge clock) disable iff (reset) in_valid |-> (in_len <= MAX_LEN_L));

endmodule

// File: tb/tb_jpeg_bitstream_packer.sv
// tb/tb_jpeg_bitstream_packer.sv - directed self-checking bench for jpeg_bitstream_packer
module tb_jpeg_bitstream_packer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_flush = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_bits = 32'h0;
    logic [5:0]  in_len = 6'd0;
    logic        in_ready, out_valid, flush_done, busy;
    logic [7:0]  out_byte;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  got[$];
    logic [7:0]  exp_q[$];
    int          flush_cnt = 0;
    int          base = 0;
    int          fbase = 0;
    logic        stable;

    always #5 clock = ~clock;

    jpeg_bitstream_packer dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bits    (in_bits),
        .in_len     (in_len),
        .in_flush   (in_flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .flush_done (flush_done),
        .busy       (busy)
    );

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) got.push_back(out_byte);
        if (!reset && flush_done) flush_cnt++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] b, input logic [5:0] l, input logic f);
        int n = 0;
        in_bits  = b;
        in_len   = l;
        in_flush = f;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) check("send_accept", 32'(in_ready), 32'(1));
        tick();
        in_valid = 1'b0;
        in_flush = 1'b0;
        in_len   = 6'd0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        if (busy) check({tag, "_idle"}, 32'(busy), 32'(0));
        tick();
        tick();
    endtask

    task automatic check_stream(input string tag, input int nflush);
        check({tag, "_count"}, 32'(got.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < got.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(got[base+i]), 32'(exp_q[i]));
        check({tag, "_flush"}, 32'(flush_cnt - fbase), 32'(nflush));
        base  = got.size();
        fbase = flush_cnt;
    endtask

    initial begin
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_flush_done", 32'(flush_done), 32'(0));
        check("rst_in_ready_low", 32'(in_ready), 32'(0));
        check("rst_out_byte", 32'(out_byte), 32'(8'h00));
        reset = 1'b0;
        #1;
        check("rst_in_ready_high", 32'(in_ready), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        base  = got.size();
        fbase = flush_cnt;

        // two nibbles make one byte
        send(32'hA, 6'd4, 1'b0);
        check("t1_no_early_valid", 32'(out_valid), 32'(0));
        send(32'h5, 6'd4, 1'b0);
        check("t1_latency_pre", 32'(out_valid), 32'(0));
        tick();
        check("t1_valid", 32'(out_valid), 32'(1));
        check("t1_byte", 32'(out_byte), 32'(8'hA5));
        wait_idle("t1");
        check("t1_busy", 32'(busy), 32'(0));
        exp_q = '{8'hA5};
        check_stream("t1", 0);

        // 0xFF data byte is followed by a stuff byte
        send(32'hFF, 6'd8, 1'b0);
        send(32'h12, 6'd8, 1'b0);
        check("t2_stuff_in_ready", 32'(in_ready), 32'(0));
        check("t2_ff_byte", 32'(out_byte), 32'(8'hFF));
        wait_idle("t2");
        exp_q = '{8'hFF, 8'h00, 8'h12};
        check_stream("t2", 0);

        // flush pads with ones
        send(32'h5, 6'd3, 1'b1);
        wait_idle("t3a");
        exp_q = '{8'hBF};
        check_stream("t3a", 1);
        send(32'hF, 6'd4, 1'b1);
        wait_idle("t3b");
        exp_q = '{8'hFF, 8'h00};
        check_stream("t3b", 1);

        // backpressure with a full accumulator
        out_ready = 1'b0;
        send(32'hDEADBEEF, 6'd32, 1'b0);
        check("t4_in_ready_at32", 32'(in_ready), 32'(1));
        send(32'hDEADBEEF, 6'd32, 1'b0);
        check("t4_in_ready_drop", 32'(in_ready), 32'(0));
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_byte !== 8'hDE || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        check("t4_stall_stable", 32'(stable), 32'(1));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(32'hDEADBEEF, 6'd32, 1'b0);
        wait_idle("t4");
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'hDE);
            exp_q.push_back(8'hAD);
            exp_q.push_back(8'hBE);
            exp_q.push_back(8'hEF);
        end
        check_stream("t4", 0);

        // empty flush emits nothing but still signals completion
        send(32'h0, 6'd0, 1'b1);
        check("t5_fd_pre", 32'(flush_done), 32'(0));
        tick();
        check("t5_fd_pulse", 32'(flush_done), 32'(1));
        check("t5_no_valid", 32'(out_valid), 32'(0));
        tick();
        check("t5_fd_off", 32'(flush_done), 32'(0));
        wait_idle("t5a");
        exp_q.delete();
        check_stream("t5a", 1);

        // 13 + 3 bits, upper input bits must be masked
        send(32'hFFFFFABC, 6'd13, 1'b0);
        send(32'hFFFFFFFD, 6'd3, 1'b0);
        wait_idle("t5b");
        exp_q = '{8'hD5, 8'hE5};
        check_stream("t5b", 0);

        // reset mid-stuff discards everything
        out_ready = 1'b0;
        send(32'h3FF, 6'd10, 1'b0);
        tick();
        check("t6_pre_valid", 32'(out_valid), 32'(1));
        reset = 1'b1;
        tick();
        check("t6_rst_valid", 32'(out_valid), 32'(0));
        check("t6_rst_flush_done", 32'(flush_done), 32'(0));
        reset = 1'b0;
        #1;
        check("t6_busy", 32'(busy), 32'(0));
        check("t6_in_ready", 32'(in_ready), 32'(1));
        base  = got.size();
        fbase = flush_cnt;
        out_ready = 1'b1;
        send(32'h81, 6'd8, 1'b0);
        wait_idle("t6");
        exp_q = '{8'h81};
        check_stream("t6", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
